bist_pattern_ctrl: RTL and testbench

BIST_PATTERN_CTRL -- requirements
Module: bist_pattern_ctrl

---
 rtl/bist_pattern_ctrl_if.sv | 24 ++
 rtl/bist_pattern_ctrl.sv | 111 +++++++++++
 tb/tb_bist_pattern_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/bist_pattern_ctrl_if.sv
// BIST controller port bundle: run control, CUT stimulus/response and status.
// The master side drives control and response; the slave side is the controller.
interface bist_pattern_ctrl_if;
  logic        start;
  logic        abort;
  logic [7:0]  resp_i;
  logic [7:0]  exp_sig_i;
  logic [11:0] pat_o;
  logic        pat_valid;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  sig_o;

  modport master (
    output start, abort, resp_i, exp_sig_i,
    input  pat_o, pat_valid, busy, done, pass, sig_o
  );

  modport slave (
    input  start, abort, resp_i, exp_sig_i,
    output pat_o, pat_valid, busy, done, pass, sig_o
  );
endinterface

// File: rtl/bist_pattern_ctrl.sv
// Logic BIST controller: 12-bit LFSR pattern source, 8-bit MISR compactor,
// run-length counter and IDLE/RUN/DONE sequencing with abort.
module bist_pattern_ctrl #(
  parameter int          N_PATTERNS = 256,
  parameter logic [11:0] LFSR_SEED  = 12'hACE,
  parameter logic [7:0]  MISR_INIT  = 8'h00
) (
  input logic             clk,
  input logic             rst_n,
  bist_pattern_ctrl_if.slave bus
);

  localparam int CW = $clog2(N_PATTERNS + 1);
  localparam logic [CW-1:0] LAST = CW'(N_PATTERNS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] lfsr_q, lfsr_d;
  logic [7:0]  misr_q, misr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [11:0] lfsr_step(
    input logic [11:0] q
  );
    logic fb;
    fb = q[11] ^ q[5] ^ q[3] ^ q[0];
    return {q[10:0], fb};
  endfunction

  function automatic logic [7:0] misr_step(
    input logic [7:0] m,
    input logic [7:0] r
  );
    logic [7:0] n;
    n[0] = m[7] ^ r[0];
    n[1] = m[0] ^ r[1];
    n[2] = m[1] ^ m[7] ^ r[2];
    n[3] = m[2] ^ m[7] ^ r[3];
    n[4] = m[3] ^ m[7] ^ r[4];
    n[5] = m[4] ^ r[5];
    n[6] = m[5] ^ r[6];
    n[7] = m[6] ^ r[7];
    return n;
  endfunction

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          lfsr_d  = LFSR_SEED;
          misr_d  = MISR_INIT;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          misr_d = misr_step(misr_q, bus.resp_i);
          cnt_d  = cnt_q + CW'(1);
          // last pattern stays on pat_o through DONE
          if (cnt_q == LAST) state_d = DONE;
          else               lfsr_d  = lfsr_step(lfsr_q);
        end
      end
      DONE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.start) begin
          state_d = RUN;
          lfsr_d  = LFSR_SEED;
          misr_d  = MISR_INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      misr_q  <= MISR_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pat_o     = lfsr_q;
  assign bus.pat_valid = (state_q == RUN);
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.sig_o     = misr_q;
  assign bus.pass      = (state_q == DONE) && (misr_q == bus.exp_sig_i);

endmodule

// File: tb/tb_bist_pattern_ctrl.sv
// Directed bench for bist_pattern_ctrl: three instances (N=2, N=1, N=256)
// sharing clock and reset, checked with immediate assertions.
module tb_bist_pattern_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   pv1 = 0;
  int   pv256 = 0;

  always #5 clk = ~clk;

  bist_pattern_ctrl_if b2 ();
  bist_pattern_ctrl_if b1 ();
  bist_pattern_ctrl_if b256 ();

  bist_pattern_ctrl #(.N_PATTERNS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2)
  );
  bist_pattern_ctrl #(.N_PATTERNS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  bist_pattern_ctrl u256 (
    .clk(clk), .rst_n(rst_n), .bus(b256)
  );

  // CUT stand-in for the long run: response is a fold of the pattern
  assign b256.resp_i = b256.pat_o[7:0] ^ b256.pat_o[11:4];

  always @(negedge clk) begin
    if (b1.pat_valid) pv1++;
    if (b256.pat_valid) pv256++;
  end

  function automatic logic [11:0] m_lfsr(input logic [11:0] q);
    return {q[10:0], q[11] ^ q[5] ^ q[3] ^ q[0]};
  endfunction

  function automatic logic [7:0] m_misr(
    input logic [7:0] m,
    input logic [7:0] r
  );
    logic [7:0] t;
    t = {m[6:0], 1'b0};
    if (m[7]) t = t ^ 8'b0001_1101;
    return t ^ r;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] l;
    logic [7:0]  m;
    logic [7:0]  ref_sig;
    logic [7:0]  sig_save;
    logic [11:0] pat_save;
    logic        prev_busy;
    int          n;

    b2.start = 0; b2.abort = 0; b2.resp_i = 8'hFF; b2.exp_sig_i = 8'h1C;
    b1.start = 0; b1.abort = 0; b1.resp_i = 8'h00; b1.exp_sig_i = 8'h00;
    b256.start = 0; b256.abort = 0; b256.exp_sig_i = 8'h00;

    l = 12'hACE;
    m = 8'h00;
    for (int i = 0; i < 256; i++) begin
      m = m_misr(m, l[7:0] ^ l[11:4]);
      l = m_lfsr(l);
    end
    ref_sig = m;

    #12;
    chk("rst_pat", {20'h0, b2.pat_o}, 32'hACE);
    chk("rst_sig", {24'h0, b2.sig_o}, 32'h00);
    chk("rst_flags",
        {28'h0, b2.pat_valid, b2.busy, b2.done, b2.pass}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("idle_hold", {30'h0, b2.busy, b2.done}, 32'h0);
    chk("idle_pat", {20'h0, b2.pat_o}, 32'hACE);

    // N=2, resp FF
    b2.start = 1; tick(); b2.start = 0;
    chk("n2_p0", {20'h0, b2.pat_o}, 32'hACE);
    chk("n2_v0", {30'h0, b2.pat_valid, b2.busy}, 32'h3);
    tick();
    chk("n2_p1", {20'h0, b2.pat_o}, 32'h59C);
    chk("n2_v1", {31'h0, b2.pat_valid}, 32'h1);
    tick();
    chk("n2_done", {29'h0, b2.done, b2.pat_valid, b2.busy}, 32'h4);
    chk("n2_sig", {24'h0, b2.sig_o}, 32'h1C);
    chk("n2_pass", {31'h0, b2.pass}, 32'h1);
    b2.exp_sig_i = 8'h1D; #1;
    chk("n2_nopass", {31'h0, b2.pass}, 32'h0);
    b2.exp_sig_i = 8'h1C;
    tick();
    chk("n2_frozen", {24'h0, b2.sig_o}, 32'h1C);

    // rerun from DONE gives the same signature
    b2.start = 1; tick(); b2.start = 0;
    chk("n2_rerun_done", {30'h0, b2.done, b2.busy}, 32'h1);
    chk("n2_rerun_pat", {20'h0, b2.pat_o}, 32'hACE);
    tick(); tick();
    chk("n2_rerun_sig", {24'h0, b2.sig_o}, 32'h1C);
    chk("n2_rerun_fin", {31'h0, b2.done}, 32'h1);

    // abort beats start in DONE
    b2.abort = 1; b2.start = 1; tick();
    b2.abort = 0; b2.start = 0;
    chk("n2_abort_st", {29'h0, b2.done, b2.busy, b2.pass}, 32'h0);
    chk("n2_abort_sig", {24'h0, b2.sig_o}, 32'h1C);
    tick();
    chk("n2_abort_idle", {31'h0, b2.busy}, 32'h0);

    // N=1, resp 00
    b1.start = 1; tick(); b1.start = 0;
    chk("n1_valid", {31'h0, b1.pat_valid}, 32'h1);
    tick();
    chk("n1_done", {30'h0, b1.done, b1.pat_valid}, 32'h2);
    chk("n1_sig", {24'h0, b1.sig_o}, 32'h00);
    tick(); tick();
    chk("n1_count", pv1, 1);

    // N=256 full run
    pv256 = 0;
    b256.start = 1; tick(); b256.start = 0;
    prev_busy = 1'b0;
    n = 0;
    while (!b256.done && n < 400) begin
      prev_busy = b256.busy;
      tick();
      n++;
    end
    chk("n256_done", {31'h0, b256.done}, 32'h1);
    chk("n256_edge", {30'h0, prev_busy, b256.busy}, 32'h2);
    chk("n256_count", pv256, 256);
    chk("n256_sig", {24'h0, b256.sig_o}, {24'h0, ref_sig});
    b256.exp_sig_i = ref_sig; #1;
    chk("n256_pass", {31'h0, b256.pass}, 32'h1);

    // abort during RUN cycle 10
    b256.start = 1; tick(); b256.start = 0;
    for (int i = 0; i < 9; i++) tick();
    chk("ab_running", {31'h0, b256.busy}, 32'h1);
    sig_save = b256.sig_o;
    pat_save = b256.pat_o;
    b256.abort = 1; tick(); b256.abort = 0;
    chk("ab_idle", {29'h0, b256.busy, b256.pat_valid, b256.done}, 32'h0);
    chk("ab_sig", {24'h0, b256.sig_o}, {24'h0, sig_save});
    chk("ab_pat", {20'h0, b256.pat_o}, {20'h0, pat_save});

    // asynchronous reset at pattern 100
    b256.start = 1; tick(); b256.start = 0;
    for (int i = 0; i < 99; i++) tick();
    chk("mid_running", {31'h0, b256.busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pat", {20'h0, b256.pat_o}, 32'hACE);
    chk("mid_rst_sig", {24'h0, b256.sig_o}, 32'h00);
    chk("mid_rst_flags",
        {28'h0, b256.pat_valid, b256.busy, b256.done, b256.pass}, 32'h0);
    tick();
    rst_n = 1'b1;
    pv256 = 0;
    tick(); tick(); tick();
    chk("mid_no_prog", pv256, 0);
    chk("mid_hold_pat", {20'h0, b256.pat_o}, 32'hACE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
